// File: rtl/mul_sched_pkg.sv
// Shared constants for the multiplier scheduler.
// State encoding and watchdog sizing.
package mul_sched_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam int WDOG_W = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester select.
// Scans req starting at ptr, wrapping modulo N_REQ.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDW-1:0]   id,
  output logic             any
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic               found;
  int                 sel;

  assign dbl = {req, req} >> ptr;
  assign rot = dbl[N_REQ-1:0];
  assign any = |req;

  // rot[k] is requester (ptr + k) mod N_REQ
  always_comb begin
    grant = '0;
    id    = '0;
    found = 1'b0;
    sel   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sel   = int'(ptr) + k;
        if (sel >= N_REQ) sel = sel - N_REQ;
      end
    end
    if (found) begin
      id    = IDW'(sel);
      grant = N_REQ'(1) << sel;
    end
  end

endmodule

// File: rtl/mul_scheduler.sv
// Shares one multiplier among N_REQ requesters.
// Single outstanding op, round-robin issue, watchdog.
module mul_scheduler
  import mul_sched_pkg::*;
#(
  parameter int C_WIDTH = 32,
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                       ctl_clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*C_WIDTH-1:0]   req_a,
  input  logic [N_REQ*C_WIDTH-1:0]   req_b,
  input  logic [N_REQ-1:0]           req_signed,
  output logic [N_REQ-1:0]           gnt,
  output logic [N_REQ-1:0]           rsp_valid,
  output logic [C_WIDTH-1:0]         rsp_y,
  output logic                       rsp_err,
  output logic                       busy,
  output logic [C_WIDTH-1:0]         mul_a,
  output logic [C_WIDTH-1:0]         mul_b,
  output logic                       mul_signed,
  output logic                       mul_trigger,
  input  logic                       mul_ready,
  input  logic                       mul_done,
  input  logic [C_WIDTH-1:0]         mul_y
);

  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [1:0]        state;
  logic [IDW-1:0]    ptr;
  logic [IDW-1:0]    id_q;
  logic [IDW-1:0]    arb_id;
  logic [N_REQ-1:0]  arb_gnt;
  logic              arb_any;
  logic [WDOG_W-1:0] wdog;

  rr_arbiter #(
    .N_REQ(N_REQ),
    .IDW  (IDW)
  ) u_arb (
    .req  (req),
    .ptr  (ptr),
    .grant(arb_gnt),
    .id   (arb_id),
    .any  (arb_any)
  );

  always_ff @(posedge ctl_clk) begin
    if (reset) begin
      state       <= S_IDLE;
      ptr         <= '0;
      id_q        <= '0;
      wdog        <= '0;
      gnt         <= '0;
      rsp_valid   <= '0;
      rsp_y       <= '0;
      rsp_err     <= 1'b0;
      busy        <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
      mul_signed  <= 1'b0;
      mul_trigger <= 1'b0;
    end else begin
      gnt         <= '0;
      rsp_valid   <= '0;
      mul_trigger <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (arb_any && mul_ready) begin
            id_q        <= arb_id;
            mul_a       <= req_a[arb_id*C_WIDTH +: C_WIDTH];
            mul_b       <= req_b[arb_id*C_WIDTH +: C_WIDTH];
            mul_signed  <= req_signed[arb_id];
            gnt         <= arb_gnt;
            mul_trigger <= 1'b1;
            busy        <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wdog  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (mul_done) begin
            rsp_y     <= mul_y;
            rsp_err   <= 1'b0;
            rsp_valid <= N_REQ'(1) << id_q;
            state     <= S_RESP;
          end else if (wdog >= WDOG_W'(TIMEOUT)) begin
            rsp_y     <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= N_REQ'(1) << id_q;
            state     <= S_RESP;
          end else if (wdog != '1) begin
            wdog <= wdog + 1'b1;
          end
        end
        S_RESP: begin
          ptr   <= (id_q == IDW'(N_REQ - 1)) ? '0 : id_q + 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_scheduler.sv
// Directed bench for mul_scheduler with a
// fixed-point (Q.8) multiplier model attached.
module tb_mul_scheduler;

  localparam int CW  = 32;
  localparam int NR  = 4;
  localparam int TO  = 10;
  localparam int LAT = 3;

  logic           ctl_clk = 1'b0;
  logic           reset;
  logic [NR-1:0]  req;
  logic [NR*CW-1:0] req_a;
  logic [NR*CW-1:0] req_b;
  logic [NR-1:0]  req_signed;
  logic [NR-1:0]  gnt;
  logic [NR-1:0]  rsp_valid;
  logic [CW-1:0]  rsp_y;
  logic           rsp_err;
  logic           busy;
  logic [CW-1:0]  mul_a;
  logic [CW-1:0]  mul_b;
  logic           mul_signed;
  logic           mul_trigger;
  logic           mul_ready;
  logic           mul_done;
  logic [CW-1:0]  mul_y;

  logic stub = 1'b0;
  logic ready_en = 1'b1;
  logic tb_done = 1'b0;
  logic mbusy;
  logic done_q;
  logic [CW-1:0] y_q;
  int   cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 ctl_clk = ~ctl_clk;

  mul_scheduler #(
    .C_WIDTH(CW),
    .N_REQ  (NR),
    .TIMEOUT(TO)
  ) dut (
    .ctl_clk    (ctl_clk),
    .reset      (reset),
    .req        (req),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_signed (req_signed),
    .gnt        (gnt),
    .rsp_valid  (rsp_valid),
    .rsp_y      (rsp_y),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_signed (mul_signed),
    .mul_trigger(mul_trigger),
    .mul_ready  (mul_ready),
    .mul_done   (mul_done),
    .mul_y      (mul_y)
  );

  function automatic logic [31:0] fx_mul(
    input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [63:0] p;
    if (s) p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    else   p = {32'b0, a} * {32'b0, b};
    return p[39:8];
  endfunction

  assign mul_ready = ready_en & ~mbusy;
  assign mul_done  = done_q | tb_done;
  assign mul_y     = y_q;

  always_ff @(posedge ctl_clk) begin
    if (reset) begin
      mbusy  <= 1'b0;
      done_q <= 1'b0;
      cnt    <= 0;
      y_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (mul_trigger && !mbusy) begin
        mbusy <= 1'b1;
        cnt   <= LAT;
        y_q   <= fx_mul(mul_a, mul_b, mul_signed);
      end else if (mbusy) begin
        if (cnt == 1) begin
          mbusy  <= 1'b0;
          done_q <= ~stub;
        end
        cnt <= cnt - 1;
      end
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_op(input int idx, input logic [31:0] a,
                          input logic [31:0] b, input logic s);
    req_a[idx*CW +: CW] = a;
    req_b[idx*CW +: CW] = b;
    req_signed[idx]     = s;
    req[idx]            = 1'b1;
  endtask

  task automatic wait_gnt(output int cyc);
    cyc = 0;
    do begin
      @(negedge ctl_clk);
      cyc++;
    end while (gnt == '0 && cyc < 30);
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    do begin
      @(negedge ctl_clk);
      cyc++;
    end while (rsp_valid == '0 && cyc < 40);
  endtask

  task automatic run_op(input string tag, input int idx,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [31:0] ey,
                        input logic ee);
    int c;
    drive_op(idx, a, b, s);
    wait_gnt(c);
    check({tag, "_gnt"}, 32'(gnt), 32'(1) << idx);
    check({tag, "_lat"}, 32'(c), 32'd1);
    check({tag, "_trig"}, 32'(mul_trigger), 32'd1);
    req[idx] = 1'b0;
    wait_rsp(c);
    check({tag, "_rv"}, 32'(rsp_valid), 32'(1) << idx);
    check({tag, "_y"}, rsp_y, ey);
    check({tag, "_err"}, 32'(rsp_err), 32'(ee));
    check({tag, "_mula"}, mul_a, a);
    @(negedge ctl_clk);
    check({tag, "_rv_pulse"}, 32'(rsp_valid), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 32'd0);
    check({tag, "_rv"}, 32'(rsp_valid), 32'd0);
    check({tag, "_y"}, rsp_y, 32'd0);
    check({tag, "_err"}, 32'(rsp_err), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_trig"}, 32'(mul_trigger), 32'd0);
    check({tag, "_a"}, mul_a, 32'd0);
    check({tag, "_b"}, mul_b, 32'd0);
    check({tag, "_sgn"}, 32'(mul_signed), 32'd0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge ctl_clk);
    reset = 1'b0;
  endtask

  initial begin
    int c;
    int id;
    logic [NR-1:0] seen;
    int order [5] = '{0, 1, 2, 3, 0};

    reset      = 1'b1;
    req        = '0;
    req_a      = '0;
    req_b      = '0;
    req_signed = '0;
    repeat (2) @(negedge ctl_clk);
    reset = 1'b0;
    check_zero("rst");

    run_op("single", 0, 32'h0000_0200, 32'h0000_0300, 1'b0,
           32'h0000_0600, 1'b0);
    run_op("signed", 2, 32'hFFFF_FE00, 32'h0000_0300, 1'b1,
           32'hFFFF_FA00, 1'b0);

    pulse_reset();

    // multiplier not ready: request must sit unserved
    ready_en = 1'b0;
    drive_op(2, 32'h100, 32'h100, 1'b0);
    seen = '0;
    repeat (5) begin
      @(negedge ctl_clk);
      seen = seen | gnt;
      if (busy) seen[0] = 1'b1;
    end
    check("notready_gnt", 32'(seen), 32'd0);
    req[2]   = 1'b0;
    ready_en = 1'b1;

    for (int i = 0; i < NR; i++)
      drive_op(i, 32'(i + 1) << 8, 32'h100, 1'b0);
    for (int g = 0; g < 5; g++) begin
      wait_gnt(c);
      check($sformatf("rr%0d_gnt", g), 32'(gnt), 32'(1) << order[g]);
      id = 0;
      for (int k = 0; k < NR; k++) if (gnt[k]) id = k;
      req[id] = 1'b0;
      wait_rsp(c);
      check($sformatf("rr%0d_rv", g), 32'(rsp_valid), 32'(1) << id);
      check($sformatf("rr%0d_y", g), rsp_y, 32'(id + 1) << 8);
      if (g < 4) req[id] = 1'b1;
    end
    req = '0;
    @(negedge ctl_clk);
    @(negedge ctl_clk);

    stub = 1'b1;
    run_op("tmo", 3, 32'h100, 32'h100, 1'b0, 32'd0, 1'b1);

    drive_op(0, 32'h200, 32'h200, 1'b0);
    wait_gnt(c);
    check("rstw_gnt", 32'(gnt), 32'd1);
    req[0] = 1'b0;
    repeat (2) @(negedge ctl_clk);
    pulse_reset();
    check_zero("rstw");
    stub    = 1'b0;
    tb_done = 1'b1;
    @(negedge ctl_clk);
    tb_done = 1'b0;
    seen = rsp_valid;
    repeat (4) begin
      @(negedge ctl_clk);
      seen = seen | rsp_valid;
    end
    check("rstw_norsp", 32'(seen), 32'd0);
    check("rstw_busy", 32'(busy), 32'd0);

    run_op("after", 1, 32'h100, 32'h100, 1'b0, 32'h100, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/mul_scheduler.md
MUL_SCHEDULER -- requirements
Module: mul_scheduler

Interface
REQ-001 SHALL have parameter C_WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter N_REQ, default 4, number of requesters (voices), range 2..8.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum WAIT cycles before error completion.
REQ-004 SHALL have ports: ctl_clk in 1 (single clock); reset in 1 (synchronous, active-high).
REQ-005 SHALL have ports: req in N_REQ (per-requester request); req_a in N_REQ*C_WIDTH (operand a, slot i at [i*C_WIDTH +: C_WIDTH]); req_b in N_REQ*C_WIDTH (operand b, same packing); req_signed in N_REQ (signed_cal per requester).
REQ-006 SHALL have ports: gnt out N_REQ (one-hot accept pulse); rsp_valid out N_REQ (one-hot result pulse); rsp_y out C_WIDTH (result); rsp_err out 1 (timeout flag, qualified by rsp_valid); busy out 1 (state != IDLE).
REQ-007 SHALL have ports to the shared multiplier: mul_a out C_WIDTH; mul_b out C_WIDTH; mul_signed out 1; mul_trigger out 1; mul_ready in 1; mul_done in 1; mul_y in C_WIDTH.

Function
REQ-008 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE; all outputs registered.
REQ-009 IDLE: if |req and mul_ready, SHALL select winner id by round-robin from pointer ptr, latch req_a/req_b/req_signed of id into mul_a/mul_b/mul_signed, go ISSUE; otherwise stay IDLE.
REQ-010 Round-robin: winner = first i with req[i]=1 scanning ptr, ptr+1, ... wrapping modulo N_REQ.
REQ-011 ISSUE (exactly one cycle): SHALL assert mul_trigger=1 and gnt[id]=1, clear watchdog, go WAIT.
REQ-012 WAIT: on mul_done=1, SHALL capture mul_y into rsp_y, rsp_err=0, go RESP; mul_done outside WAIT SHALL be ignored.
REQ-013 WAIT: if watchdog reaches TIMEOUT with no mul_done, SHALL set rsp_y=0, rsp_err=1, go RESP.
REQ-014 RESP (exactly one cycle): SHALL assert rsp_valid[id]=1 with rsp_y/rsp_err stable, set ptr=(id+1) mod N_REQ, go IDLE.
REQ-015 Latency: req sampled at IDLE edge k -> gnt/mul_trigger in cycle k+1 -> rsp_valid in cycle d+1, where d is the WAIT cycle with mul_done.
REQ-016 mul_a/mul_b/mul_signed SHALL stay constant from ISSUE through RESP.
REQ-017 Requester handshake: hold req and operands stable until gnt; deassert req the cycle after gnt unless a new operation is pending; req dropped before sampling SHALL produce no gnt.
REQ-018 Requester i SHALL NOT be selected again until rsp_valid[i] has fired for its previous operation (guaranteed by the single-outstanding FSM).
REQ-019 mul_ready=0 in IDLE SHALL hold IDLE, no gnt, ptr unchanged.
REQ-020 gnt, rsp_valid, mul_trigger SHALL be single-cycle pulses, at most one bit of gnt/rsp_valid set.
REQ-021 Watchdog SHALL be an 8..16-bit saturating counter, wide enough for TIMEOUT.

Reset
REQ-022 reset=1 at a ctl_clk edge SHALL force IDLE, ptr=0, watchdog=0, gnt=0, rsp_valid=0, rsp_y=0, rsp_err=0, busy=0, mul_trigger=0, mul_a=0, mul_b=0, mul_signed=0.
REQ-023 reset mid-operation SHALL abandon the operation with no rsp_valid; a later mul_done SHALL be ignored in IDLE.

Structure
REQ-024 Package mul_sched_pkg SHALL hold FSM state encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3) and the watchdog width constant.
REQ-025 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req, ptr; outputs one-hot grant, binary id, any).

Verification
REQ-026 Bench SHALL connect multiplier (MUL_TYPE=1, FIXED_POINT=8, C_WIDTH=32) and cover:
REQ-027 Single: req[0], a=0x00000200, b=0x00000300, unsigned -> gnt[0] one cycle after sampling, rsp_valid[0] with rsp_y=0x00000600, rsp_err=0.
REQ-028 Signed: req[2], a=0xFFFFFE00, b=0x00000300, signed=1 -> rsp_valid[2], rsp_y=0xFFFFFA00.
REQ-029 Contention: req=4'b1111 held, re-raised after each gnt -> grant order 0,1,2,3,0, each rsp_valid index matching its gnt.
REQ-030 Timeout: stub multiplier never asserts mul_done, TIMEOUT=10 -> rsp_valid[id]=1, rsp_err=1, rsp_y=0, FSM back in IDLE.
REQ-031 Reset in WAIT: reset pulse, then stub mul_done -> no rsp_valid, all outputs zero, next req[1] served normally.
